// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath types: word width, MDR source select codes, memory FSM states.
// Pure declarations; no logic, so no latency and no flow control.
package lc3_pkg;

    localparam int LC3_WORD_W = 16;

    typedef enum logic [1:0] {
        SEL_MDR_BUS  = 2'b00,
        SEL_MDR_MEM  = 2'b01,
        SEL_MDR_LOAD = 2'b10
    } sel_mdr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10
    } mem_state_t;

endpackage

// File: rtl/lc3_memory_unit_if.sv
// Control-unit to memory-stage bundle: load strobes, bus and preload inputs, MAR/MDR/bus outputs.
// Master is the control unit; slave is the memory unit, which reports busy on mem_ready.
interface lc3_memory_unit_if;
    import lc3_pkg::*;

    logic [LC3_WORD_W-1:0] bus_in;
    logic                  ldMAR;
    logic                  ldMDR;
    logic [1:0]            selMDR;
    logic                  memWE;
    logic                  enaMDR;
    logic                  ldMARSpcIn;
    logic [LC3_WORD_W-1:0] MARSpcIn;
    logic [LC3_WORD_W-1:0] MDRSpcIn;
    logic [LC3_WORD_W-1:0] mar_out;
    logic [LC3_WORD_W-1:0] mdr_out;
    logic [LC3_WORD_W-1:0] bus_drive;
    logic                  bus_drive_en;
    logic                  mem_ready;

    modport master (
        output bus_in, ldMAR, ldMDR, selMDR, memWE, enaMDR, ldMARSpcIn, MARSpcIn, MDRSpcIn,
        input  mar_out, mdr_out, bus_drive, bus_drive_en, mem_ready
    );

    modport slave (
        input  bus_in, ldMAR, ldMDR, selMDR, memWE, enaMDR, ldMARSpcIn, MARSpcIn, MDRSpcIn,
        output mar_out, mdr_out, bus_drive, bus_drive_en, mem_ready
    );

endinterface

// File: rtl/lc3_ram.sv
// Single-port word RAM: write on the rising edge when we=1, read is combinational at addr.
// No reset and no flow control; contents are undefined until written.
module lc3_ram
    import lc3_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [LC3_WORD_W-1:0] wdata,
    output logic [LC3_WORD_W-1:0] rdata
);

    logic [LC3_WORD_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/lc3_memory_unit.sv
// LC-3 memory stage: MAR, MDR and RAM; preload and bus loads take 1 edge, reads/writes MEM_LAT edges.
// mem_ready is low while an access runs; requests arriving then are dropped, never queued.
module lc3_memory_unit
    import lc3_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    lc3_memory_unit_if.slave  mem_if
);

    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

    mem_state_t            state, state_nxt;
    logic [3:0]            lat_cnt, lat_cnt_nxt;
    logic [LC3_WORD_W-1:0] mar, mar_nxt;
    logic [LC3_WORD_W-1:0] mdr, mdr_nxt;
    logic [LC3_WORD_W-1:0] lat_data, lat_data_nxt;
    logic [ADDR_W-1:0]     lat_addr, lat_addr_nxt;

    logic                  ram_we;
    logic [ADDR_W-1:0]     ram_addr;
    logic [LC3_WORD_W-1:0] ram_wdata;
    logic [LC3_WORD_W-1:0] ram_rdata;

    lc3_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            lat_cnt  <= 4'd0;
            mar      <= '0;
            mdr      <= '0;
            lat_addr <= '0;
            lat_data <= '0;
        end else begin
            state    <= state_nxt;
            lat_cnt  <= lat_cnt_nxt;
            mar      <= mar_nxt;
            mdr      <= mdr_nxt;
            lat_addr <= lat_addr_nxt;
            lat_data <= lat_data_nxt;
        end
    end

    // The RAM port is steered to the preload address only in the preload cycle;
    // otherwise it points at the latched access address so read data is ready on exit.
    always_comb begin
        state_nxt    = state;
        lat_cnt_nxt  = lat_cnt;
        mar_nxt      = mar;
        mdr_nxt      = mdr;
        lat_addr_nxt = lat_addr;
        lat_data_nxt = lat_data;
        ram_we       = 1'b0;
        ram_addr     = lat_addr;
        ram_wdata    = lat_data;

        case (state)
            IDLE: begin
                if (mem_if.ldMARSpcIn) begin
                    ram_we    = 1'b1;
                    ram_addr  = mem_if.MARSpcIn[ADDR_W-1:0];
                    ram_wdata = mem_if.MDRSpcIn;
                    mar_nxt   = mem_if.MARSpcIn;
                    mdr_nxt   = mem_if.MDRSpcIn;
                end else if (mem_if.memWE) begin
                    state_nxt    = WRITE;
                    lat_cnt_nxt  = LAT_INIT;
                    lat_addr_nxt = mar[ADDR_W-1:0];
                    lat_data_nxt = mdr;
                end else if (mem_if.ldMDR && mem_if.selMDR == SEL_MDR_MEM) begin
                    state_nxt    = READ;
                    lat_cnt_nxt  = LAT_INIT;
                    lat_addr_nxt = mar[ADDR_W-1:0];
                end else begin
                    if (mem_if.ldMDR) begin
                        if (mem_if.selMDR == SEL_MDR_BUS)       mdr_nxt = mem_if.bus_in;
                        else if (mem_if.selMDR == SEL_MDR_LOAD) mdr_nxt = mem_if.MDRSpcIn;
                    end
                    if (mem_if.ldMAR) mar_nxt = mem_if.bus_in;
                end
            end
            READ: begin
                if (lat_cnt == 4'd0) begin
                    state_nxt = IDLE;
                    mdr_nxt   = ram_rdata;
                end else begin
                    lat_cnt_nxt = lat_cnt - 4'd1;
                end
            end
            WRITE: begin
                if (lat_cnt == 4'd0) begin
                    state_nxt = IDLE;
                    ram_we    = 1'b1;
                end else begin
                    lat_cnt_nxt = lat_cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_if.mar_out      = mar;
    assign mem_if.mdr_out      = mdr;
    assign mem_if.mem_ready    = (state == IDLE);
    assign mem_if.bus_drive_en = mem_if.enaMDR;
    assign mem_if.bus_drive    = mem_if.enaMDR ? mdr : '0;

endmodule

// File: tb/tb_lc3_memory_unit.sv
// Bench for lc3_memory_unit (ADDR_W=8, MEM_LAT=2): directed scenarios plus a randomized
// sequence checked against an array-based model of MAR, MDR and memory.
module tb_lc3_memory_unit;

    localparam int MEM_LAT = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    lc3_memory_unit_if mif ();

    lc3_memory_unit #(.ADDR_W(8), .MEM_LAT(MEM_LAT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .mem_if  (mif.slave)
    );

    int errors = 0;
    int checks = 0;

    logic [15:0] ref_mem [256];
    logic [15:0] ref_mar;
    logic [15:0] ref_mdr;
    logic [7:0]  wq [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mif.bus_in = '0; mif.ldMAR = 0; mif.ldMDR = 0; mif.selMDR = 2'b00;
        mif.memWE = 0; mif.enaMDR = 0; mif.ldMARSpcIn = 0;
        mif.MARSpcIn = '0; mif.MDRSpcIn = '0;
    endtask

    task automatic do_preload(input logic [15:0] a, input logic [15:0] d);
        mif.ldMARSpcIn = 1; mif.MARSpcIn = a; mif.MDRSpcIn = d;
        step();
        mif.ldMARSpcIn = 0;
    endtask

    task automatic do_ldmar(input logic [15:0] v);
        mif.bus_in = v; mif.ldMAR = 1;
        step();
        mif.ldMAR = 0;
    endtask

    task automatic do_ldmdr(input logic [1:0] sel, input logic [15:0] v);
        mif.bus_in = v; mif.MDRSpcIn = v; mif.selMDR = sel; mif.ldMDR = 1;
        step();
        mif.ldMDR = 0; mif.selMDR = 2'b00;
    endtask

    // Issues one access and counts edges until mem_ready returns (bounded).
    task automatic do_access(input bit is_write, output int lat);
        if (is_write) mif.memWE = 1;
        else begin mif.ldMDR = 1; mif.selMDR = 2'b01; end
        step();
        mif.memWE = 0; mif.ldMDR = 0; mif.selMDR = 2'b00;
        lat = 0;
        while (!mif.mem_ready && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 0;
        step(); step();
        checks++; if (mif.mar_out !== 16'h0) begin errors++; $display("FAIL reset_mar got=%h exp=0000", mif.mar_out); end
        checks++; if (mif.mdr_out !== 16'h0) begin errors++; $display("FAIL reset_mdr got=%h exp=0000", mif.mdr_out); end
        checks++; if (mif.mem_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", mif.mem_ready); end
        checks++; if (mif.bus_drive_en !== 1'b0) begin errors++; $display("FAIL reset_bus_en got=%b exp=0", mif.bus_drive_en); end
        reset_n = 1;
        step();
        mif.enaMDR = 1; #1;
        checks++; if (mif.bus_drive_en !== 1'b1 || mif.bus_drive !== 16'h0) begin
            errors++; $display("FAIL reset_drive got=%b/%h exp=1/0000", mif.bus_drive_en, mif.bus_drive); end
        mif.enaMDR = 0;
    endtask

    task automatic test_preload_read();
        int lat;
        do_preload(16'h0003, 16'h1234);
        checks++; if (mif.mar_out !== 16'h0003 || mif.mdr_out !== 16'h1234 || mif.mem_ready !== 1'b1) begin
            errors++; $display("FAIL preload got=%h/%h/%b exp=0003/1234/1", mif.mar_out, mif.mdr_out, mif.mem_ready); end
        do_ldmdr(2'b00, 16'h0000);
        do_ldmar(16'h0003);
        do_access(0, lat);
        checks++; if (lat !== MEM_LAT) begin errors++; $display("FAIL read_latency got=%0d exp=%0d", lat, MEM_LAT); end
        checks++; if (mif.mdr_out !== 16'h1234) begin errors++; $display("FAIL read_data got=%h exp=1234", mif.mdr_out); end
        mif.enaMDR = 1; #1;
        checks++; if (mif.bus_drive !== 16'h1234) begin errors++; $display("FAIL bus_drive got=%h exp=1234", mif.bus_drive); end
        mif.enaMDR = 0;
    endtask

    task automatic test_write_timing();
        int lat;
        do_preload(16'h0010, 16'h0000);
        do_ldmdr(2'b00, 16'hBEEF);
        do_ldmar(16'h0010);
        mif.memWE = 1;
        step();
        mif.memWE = 0;
        checks++; if (mif.mem_ready !== 1'b0 || dut.u_ram.mem[8'h10] !== 16'h0000) begin
            errors++; $display("FAIL write_t1 ready=%b mem=%h exp=0/0000", mif.mem_ready, dut.u_ram.mem[8'h10]); end
        step();
        checks++; if (mif.mem_ready !== 1'b0 || dut.u_ram.mem[8'h10] !== 16'h0000) begin
            errors++; $display("FAIL write_t2 ready=%b mem=%h exp=0/0000", mif.mem_ready, dut.u_ram.mem[8'h10]); end
        step();
        checks++; if (mif.mem_ready !== 1'b1 || dut.u_ram.mem[8'h10] !== 16'hBEEF) begin
            errors++; $display("FAIL write_t3 ready=%b mem=%h exp=1/beef", mif.mem_ready, dut.u_ram.mem[8'h10]); end
        do_ldmdr(2'b00, 16'h0000);
        do_access(0, lat);
        checks++; if (mif.mdr_out !== 16'hBEEF) begin errors++; $display("FAIL write_readback got=%h exp=beef", mif.mdr_out); end
    endtask

    task automatic test_busy_drop();
        int n;
        do_preload(16'h0030, 16'hA5A5);
        do_ldmdr(2'b00, 16'h0000);
        mif.ldMDR = 1; mif.selMDR = 2'b01;
        step();
        mif.selMDR = 2'b00; mif.bus_in = 16'h5555; mif.ldMAR = 1;
        n = 0;
        while (!mif.mem_ready && n < 40) begin
            checks++; if (mif.mar_out !== 16'h0030 || mif.mdr_out !== 16'h0000) begin
                errors++; $display("FAIL busy_hold got=%h/%h exp=0030/0000", mif.mar_out, mif.mdr_out); end
            mif.bus_in = (n == 0) ? 16'h5555 : 16'h0020;
            step();
            n++;
        end
        idle_inputs();
        checks++; if (n !== MEM_LAT || mif.mdr_out !== 16'hA5A5 || mif.mar_out !== 16'h0030) begin
            errors++; $display("FAIL busy_drop cycles=%0d mdr=%h mar=%h exp=%0d/a5a5/0030", n, mif.mdr_out, mif.mar_out, MEM_LAT); end
    endtask

    task automatic test_alias_priority();
        int lat;
        do_preload(16'h0105, 16'h7777);
        checks++; if (mif.mar_out !== 16'h0105) begin errors++; $display("FAIL alias_mar got=%h exp=0105", mif.mar_out); end
        do_ldmdr(2'b00, 16'h0000);
        do_ldmar(16'h0005);
        do_access(0, lat);
        checks++; if (mif.mdr_out !== 16'h7777) begin errors++; $display("FAIL alias_read got=%h exp=7777", mif.mdr_out); end
        do_preload(16'h0040, 16'h1111);
        do_ldmdr(2'b00, 16'h4242);
        mif.memWE = 1; mif.ldMDR = 1; mif.selMDR = 2'b01;
        step();
        idle_inputs();
        lat = 0;
        while (!mif.mem_ready && lat < 40) begin step(); lat++; end
        checks++; if (mif.mdr_out !== 16'h4242 || lat !== MEM_LAT) begin
            errors++; $display("FAIL prio_no_read mdr=%h lat=%0d exp=4242/%0d", mif.mdr_out, lat, MEM_LAT); end
        do_ldmdr(2'b00, 16'h0000);
        do_access(0, lat);
        checks++; if (mif.mdr_out !== 16'h4242) begin errors++; $display("FAIL prio_write got=%h exp=4242", mif.mdr_out); end
    endtask

    task automatic test_back_to_back();
        int lat;
        do_ldmar(16'h0060);
        do_ldmdr(2'b00, 16'hCAFE);
        mif.memWE = 1;
        repeat (MEM_LAT + 2) step();
        mif.memWE = 0;
        checks++; if (mif.mem_ready !== 1'b0) begin errors++; $display("FAIL level_rewrite ready=%b exp=0", mif.mem_ready); end
        lat = 0;
        while (!mif.mem_ready && lat < 40) begin step(); lat++; end
        do_ldmdr(2'b00, 16'h0000);
        do_access(0, lat);
        checks++; if (mif.mdr_out !== 16'hCAFE) begin errors++; $display("FAIL b2b_data got=%h exp=cafe", mif.mdr_out); end
    endtask

    task automatic test_reset_mid_write();
        int lat;
        do_preload(16'h0050, 16'h9999);
        do_ldmdr(2'b00, 16'h6666);
        mif.memWE = 1;
        step();
        mif.memWE = 0;
        step();
        reset_n = 0; #1;
        checks++; if (mif.mar_out !== 16'h0 || mif.mdr_out !== 16'h0 || mif.mem_ready !== 1'b1) begin
            errors++; $display("FAIL abort_state got=%h/%h/%b exp=0000/0000/1", mif.mar_out, mif.mdr_out, mif.mem_ready); end
        step(); step();
        reset_n = 1;
        step();
        do_ldmar(16'h0050);
        do_access(0, lat);
        checks++; if (mif.mdr_out !== 16'h9999) begin errors++; $display("FAIL abort_mem got=%h exp=9999", mif.mdr_out); end
    endtask

    task automatic test_random();
        int lat;
        logic [15:0] a, d;
        logic [1:0] sel;
        logic [7:0] idx;
        a = 16'($urandom); d = 16'($urandom);
        do_preload(a, d);
        ref_mem[a[7:0]] = d; wq.push_back(a[7:0]); ref_mar = a; ref_mdr = d;
        for (int i = 0; i < 60; i++) begin
            a = 16'($urandom); d = 16'($urandom);
            case ($urandom_range(0, 3))
                0: begin
                    do_preload(a, d);
                    ref_mem[a[7:0]] = d; wq.push_back(a[7:0]); ref_mar = a; ref_mdr = d;
                end
                1: begin
                    do_ldmdr(2'b00, d);
                    do_ldmar(a);
                    do_access(1, lat);
                    ref_mem[a[7:0]] = d; wq.push_back(a[7:0]); ref_mar = a; ref_mdr = d;
                    checks++; if (lat !== MEM_LAT) begin errors++; $display("FAIL rnd_wlat i=%0d got=%0d exp=%0d", i, lat, MEM_LAT); end
                end
                2: begin
                    idx = wq[$urandom_range(0, wq.size() - 1)];
                    a = {a[15:8], idx};
                    do_ldmar(a);
                    do_access(0, lat);
                    ref_mar = a; ref_mdr = ref_mem[idx];
                    checks++; if (lat !== MEM_LAT) begin errors++; $display("FAIL rnd_rlat i=%0d got=%0d exp=%0d", i, lat, MEM_LAT); end
                end
                default: begin
                    sel = ($urandom_range(0, 2) == 0) ? 2'b11 : (($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10);
                    do_ldmdr(sel, d);
                    if (sel != 2'b11) ref_mdr = d;
                end
            endcase
            mif.enaMDR = 1'($urandom);
            #1;
            checks++; if (mif.mar_out !== ref_mar || mif.mdr_out !== ref_mdr || mif.mem_ready !== 1'b1) begin
                errors++; $display("FAIL rnd_state i=%0d got=%h/%h/%b exp=%h/%h/1", i, mif.mar_out, mif.mdr_out, mif.mem_ready, ref_mar, ref_mdr); end
            checks++; if (mif.bus_drive !== (mif.enaMDR ? ref_mdr : 16'h0) || mif.bus_drive_en !== mif.enaMDR) begin
                errors++; $display("FAIL rnd_drive i=%0d got=%h/%b exp=%h", i, mif.bus_drive, mif.bus_drive_en, mif.enaMDR ? ref_mdr : 16'h0); end
            mif.enaMDR = 0;
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_preload_read();
        test_write_timing();
        test_busy_drop();
        test_alias_priority();
        test_back_to_back();
        test_reset_mid_write();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
